// File: rtl/if_fetch_ctrl.sv
// Fetch-stage sequencer: one outstanding SRAM request, credit-limited response FIFO, redirect/discard handling.
// Define IF_FETCH_PERF_EN to add the perf_fetch_cnt / perf_discard_cnt counters.
module if_fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h1c000000,
    parameter int          BUF_DEPTH = 2,
    parameter logic [31:0] NOP_INST  = 32'h02800000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        wb_flush,
    input  logic [31:0] wb_flush_pc,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        inst_sram_req,
    output logic [31:0] inst_sram_addr,
    input  logic        inst_sram_addr_ok,
    input  logic        inst_sram_data_ok,
    input  logic [31:0] inst_sram_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        if_adef,
    input  logic        id_allow_in
`ifdef IF_FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_discard_cnt
`endif
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t             state, state_nxt;
    logic [31:0]        fetch_pc, pc_nxt;
    logic               discard, discard_nxt;
    logic               adef_done, adef_done_nxt;
    logic               req_q;

    logic [31:0]        fifo_pc   [BUF_DEPTH];
    logic [31:0]        fifo_inst [BUF_DEPTH];
    logic               fifo_adef [BUF_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count;

    logic               push, push_adef;
    logic [31:0]        push_inst;
    logic               pop, redirect, addr_acc, pc_misaligned;
    logic [31:0]        redirect_pc;
    logic [CNT_W-1:0]   occ_after_pop;
    logic               slot_free, credit_after_push;

    assign redirect          = wb_flush | br_taken;
    assign redirect_pc       = wb_flush ? wb_flush_pc : br_target;
    assign if_valid          = (count != '0);
    assign pop               = if_valid & id_allow_in & ~redirect;
    assign occ_after_pop     = count - CNT_W'(pop);
    assign slot_free         = occ_after_pop < CNT_W'(BUF_DEPTH);
    assign credit_after_push = occ_after_pop < CNT_W'(BUF_DEPTH - 1);
    assign addr_acc          = req_q & inst_sram_addr_ok;
    assign pc_misaligned     = (fetch_pc[1:0] != 2'b00);

    assign inst_sram_req  = req_q;
    assign inst_sram_addr = fetch_pc;
    assign if_pc          = if_valid ? fifo_pc[rd_ptr]   : 32'h0;
    assign if_inst        = if_valid ? fifo_inst[rd_ptr] : 32'h0;
    assign if_adef        = if_valid & fifo_adef[rd_ptr];

    always_comb begin
        state_nxt     = state;
        pc_nxt        = fetch_pc;
        discard_nxt   = discard;
        adef_done_nxt = adef_done;
        push          = 1'b0;
        push_inst     = inst_sram_rdata;
        push_adef     = 1'b0;
        if (redirect) begin
            pc_nxt        = redirect_pc;
            adef_done_nxt = 1'b0;
            if (discard) begin
                // Already draining a stale beat: only the restart PC changes.
                if (inst_sram_data_ok) begin
                    discard_nxt = 1'b0;
                    state_nxt   = S_REQ;
                end
            end else begin
                case (state)
                    S_WAIT: begin
                        if (inst_sram_data_ok) state_nxt = S_REQ;
                        else                   discard_nxt = 1'b1;
                    end
                    S_REQ: begin
                        if (addr_acc) begin
                            discard_nxt = 1'b1;
                            state_nxt   = S_WAIT;
                        end else begin
                            state_nxt = S_REQ;
                        end
                    end
                    default: state_nxt = S_REQ;
                endcase
            end
        end else begin
            case (state)
                S_IDLE, S_REQ: begin
                    if (pc_misaligned) begin
                        // Faulting PC: emit one ADEF marker, then park until redirected.
                        state_nxt = S_IDLE;
                        if (!adef_done && slot_free) begin
                            push          = 1'b1;
                            push_inst     = NOP_INST;
                            push_adef     = 1'b1;
                            adef_done_nxt = 1'b1;
                        end
                    end else if (state == S_IDLE) begin
                        if (slot_free) state_nxt = S_REQ;
                    end else if (addr_acc) begin
                        state_nxt = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (inst_sram_data_ok) begin
                        if (discard) begin
                            discard_nxt = 1'b0;
                            state_nxt   = S_REQ;
                        end else begin
                            push      = 1'b1;
                            pc_nxt    = fetch_pc + 32'd4;
                            state_nxt = credit_after_push ? S_REQ : S_IDLE;
                        end
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= S_IDLE;
            fetch_pc  <= RESET_PC;
            discard   <= 1'b0;
            adef_done <= 1'b0;
            req_q     <= 1'b0;
        end else begin
            state     <= state_nxt;
            fetch_pc  <= pc_nxt;
            discard   <= discard_nxt;
            adef_done <= adef_done_nxt;
            req_q     <= (state_nxt == S_REQ) && (pc_nxt[1:0] == 2'b00);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (redirect) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr]   <= fetch_pc;
            fifo_inst[wr_ptr] <= push_inst;
            fifo_adef[wr_ptr] <= push_adef;
        end
    end

`ifdef IF_FETCH_PERF_EN
    logic beat_dropped;
    assign beat_dropped = inst_sram_data_ok & (discard | (redirect & (state == S_WAIT)));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_fetch_cnt   <= 32'h0;
            perf_discard_cnt <= 32'h0;
        end else begin
            perf_fetch_cnt   <= perf_fetch_cnt + 32'(push);
            perf_discard_cnt <= perf_discard_cnt + 32'(beat_dropped);
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Scoreboard bench for if_fetch_ctrl: directed scenarios followed by randomized SRAM latency, ID stalls and redirects.
module tb_if_fetch_ctrl;

    localparam logic [31:0] RESET_PC = 32'h1c000000;
    localparam logic [31:0] NOP      = 32'h02800000;

    logic        clk = 1'b0;
    logic        resetn;
    logic        wb_flush, br_taken;
    logic [31:0] wb_flush_pc, br_target;
    logic        inst_sram_req, inst_sram_addr_ok, inst_sram_data_ok;
    logic [31:0] inst_sram_addr, inst_sram_rdata;
    logic        if_valid, if_adef, id_allow_in;
    logic [31:0] if_pc, if_inst;

    if_fetch_ctrl #(.RESET_PC(RESET_PC), .BUF_DEPTH(2), .NOP_INST(NOP)) dut (
        .clk(clk), .resetn(resetn),
        .wb_flush(wb_flush), .wb_flush_pc(wb_flush_pc),
        .br_taken(br_taken), .br_target(br_target),
        .inst_sram_req(inst_sram_req), .inst_sram_addr(inst_sram_addr),
        .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
        .inst_sram_rdata(inst_sram_rdata),
        .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst), .if_adef(if_adef),
        .id_allow_in(id_allow_in)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adef;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   pop_cnt  = 0;
    bit   seen_deadbeef = 0;

    // Responder state
    int          resp_mode = 0;
    int          fix_delay = -1;
    bit          fix_data_en = 0;
    logic [31:0] fix_data = 32'h0;
    int          fix_hits = 0;
    int          acc_cnt = 0;
    bit          pending = 0, pend_fix_data = 0;
    logic [31:0] pend_addr = 32'h0;
    int          pend_dly = 0;
    bit          prev_acc = 0, prev_dok = 0, prev_stall = 0;
    logic [31:0] prev_addr = 32'h0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h9e3779b9;
    endfunction

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Expected stream after a (re)start at pc: sequential words, or a single ADEF marker.
    function void sb_restart(input logic [31:0] pc);
        exp_t e;
        sb_q.delete();
        if (pc[1:0] != 2'b00) begin
            e.pc = pc; e.inst = NOP; e.adef = 1'b1;
            sb_q.push_back(e);
        end else begin
            for (int i = 0; i < 64; i++) begin
                e.pc = pc + 32'(4 * i); e.inst = mem_word(e.pc); e.adef = 1'b0;
                sb_q.push_back(e);
            end
        end
    endfunction

    // SRAM responder: accepts via addr_ok, answers the accepted address after a delay.
    initial begin
        inst_sram_addr_ok = 1'b0;
        inst_sram_data_ok = 1'b0;
        inst_sram_rdata   = 32'h0;
        forever begin
            @(posedge clk); #1;
            if (!resetn) begin
                pending = 0; prev_acc = 0; prev_dok = 0; prev_stall = 0;
                inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b0;
                continue;
            end
            if (prev_dok) pending = 0;
            if (prev_acc) begin
                acc_cnt++;
                pending = 1; pend_addr = prev_addr; pend_fix_data = fix_data_en;
                if (fix_delay >= 0) begin
                    pend_dly = fix_delay; fix_delay = -1; fix_data_en = 0; fix_hits++;
                end else begin
                    pend_dly = (resp_mode == 0) ? 0 : int'($urandom_range(0, 3));
                end
            end
            if (inst_sram_req) begin
                chk(!pending, "req_while_outstanding", inst_sram_addr, 32'h0);
                chk(inst_sram_addr[1:0] == 2'b00, "req_misaligned", inst_sram_addr, {inst_sram_addr[31:2], 2'b00});
            end
            if (prev_stall && !(wb_flush || br_taken))
                chk(inst_sram_req && inst_sram_addr == prev_addr, "req_hold", inst_sram_addr, prev_addr);
            if (pending && pend_dly == 0) begin
                inst_sram_data_ok = 1'b1;
                inst_sram_rdata   = pend_fix_data ? fix_data : mem_word(pend_addr);
            end else begin
                inst_sram_data_ok = 1'b0;
                inst_sram_rdata   = $urandom;
                if (pending) pend_dly--;
            end
            inst_sram_addr_ok = (resp_mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
            prev_acc   = inst_sram_req && inst_sram_addr_ok;
            prev_stall = inst_sram_req && !inst_sram_addr_ok;
            prev_addr  = inst_sram_addr;
            prev_dok   = inst_sram_data_ok;
        end
    end

    // Monitor: every accepted head entry is checked against the scoreboard.
    always @(negedge clk) begin
        if (resetn && if_valid && if_inst == 32'hdeadbeef) seen_deadbeef = 1;
        if (resetn && if_valid && id_allow_in && !(wb_flush || br_taken)) begin
            pop_cnt++;
            if (sb_q.size() == 0) begin
                chk(0, "sb_unexpected_pop", if_pc, 32'h0);
            end else begin
                mon_e = sb_q.pop_front();
                chk(if_pc == mon_e.pc, "pop_pc", if_pc, mon_e.pc);
                chk(if_inst == mon_e.inst, "pop_inst", if_inst, mon_e.inst);
                chk(if_adef == mon_e.adef, "pop_adef", 32'(if_adef), 32'(mon_e.adef));
            end
        end
    end

    task automatic step();
        @(posedge clk); #2;
    endtask

    task automatic redirect(input bit wb, input logic [31:0] wpc, input bit br, input logic [31:0] bpc);
        wb_flush = wb; wb_flush_pc = wpc; br_taken = br; br_target = bpc;
        sb_restart(wb ? wpc : bpc);
        step();
        wb_flush = 1'b0; br_taken = 1'b0;
    endtask

    task automatic wait_req(input string name, input logic [31:0] exp_addr);
        int n = 0;
        while (!inst_sram_req && n < 100) begin step(); n++; end
        chk(inst_sram_req && inst_sram_addr == exp_addr, name, inst_sram_addr, exp_addr);
    endtask

    task automatic wait_fix();
        int h = fix_hits;
        int n = 0;
        while (fix_hits == h && n < 100) begin step(); n++; end
        chk(fix_hits != h, "fixed_beat_accept", 32'(fix_hits), 32'(h + 1));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int first_v, vcnt, rc, since, sel;
        logic [31:0] wpc, bpc;
        resetn = 1'b0; wb_flush = 1'b0; br_taken = 1'b0;
        wb_flush_pc = 32'h0; br_target = 32'h0; id_allow_in = 1'b1;
        step(); step();

        chk(inst_sram_req == 1'b0, "rst_req", 32'(inst_sram_req), 32'h0);
        chk(inst_sram_addr == RESET_PC, "rst_addr", inst_sram_addr, RESET_PC);
        chk(if_valid == 1'b0, "rst_if_valid", 32'(if_valid), 32'h0);
        chk(if_pc == 32'h0, "rst_if_pc", if_pc, 32'h0);
        chk(if_inst == 32'h0, "rst_if_inst", if_inst, 32'h0);
        chk(if_adef == 1'b0, "rst_if_adef", 32'(if_adef), 32'h0);

        // Zero-wait streaming from reset
        resetn = 1'b1; sb_restart(RESET_PC);
        first_v = 0; vcnt = 0;
        for (int n = 1; n <= 12; n++) begin
            step();
            if (if_valid) begin
                vcnt++;
                if (first_v == 0) first_v = n;
            end
        end
        chk(first_v == 3, "first_valid_latency", 32'(first_v), 32'd3);
        chk(vcnt == 5, "valid_cycles_in_12", 32'(vcnt), 32'd5);

        // ID stall fills the buffer and stops requests
        resetn = 1'b0; id_allow_in = 1'b0;
        step();
        resetn = 1'b1; sb_restart(RESET_PC); acc_cnt = 0;
        for (int n = 0; n < 10; n++) step();
        chk(acc_cnt == 2, "stall_accepts", 32'(acc_cnt), 32'd2);
        chk(inst_sram_req == 1'b0, "stall_req_low", 32'(inst_sram_req), 32'h0);
        chk(if_valid == 1'b1, "stall_head_valid", 32'(if_valid), 32'h1);
        id_allow_in = 1'b1;
        for (int n = 0; n < 6; n++) step();

        // Flush while waiting; the stale beat must be swallowed
        seen_deadbeef = 0;
        fix_data = 32'hdeadbeef; fix_data_en = 1; fix_delay = 3;
        wait_fix();
        redirect(1'b1, 32'h1c008000, 1'b0, 32'h0);
        wait_req("flush_next_req_addr", 32'h1c008000);
        for (int n = 0; n < 10; n++) step();
        chk(!seen_deadbeef, "stale_beat_hidden", 32'(seen_deadbeef), 32'h0);

        // wb_flush wins over br_taken
        redirect(1'b1, 32'h1c00a000, 1'b1, 32'h1c000100);
        wait_req("dual_redirect_addr", 32'h1c00a000);
        for (int n = 0; n < 6; n++) step();

        // Misaligned target: one ADEF entry, no bus traffic
        redirect(1'b0, 32'h0, 1'b1, 32'h1c000102);
        rc = 0;
        for (int n = 0; n < 20; n++) begin
            if (inst_sram_req) rc++;
            step();
        end
        chk(rc == 0, "adef_no_req", 32'(rc), 32'h0);
        chk(sb_q.size() == 0, "adef_entry_popped", 32'(sb_q.size()), 32'h0);

        // data_ok in the same cycle as a redirect
        redirect(1'b0, 32'h0, 1'b1, 32'h1c000300);
        fix_data_en = 0; fix_delay = 0;
        wait_fix();
        chk(inst_sram_data_ok == 1'b1, "dok_with_redirect", 32'(inst_sram_data_ok), 32'h1);
        redirect(1'b0, 32'h0, 1'b1, 32'h1c000200);
        chk(inst_sram_req && inst_sram_addr == 32'h1c000200, "same_cycle_dok_req", inst_sram_addr, 32'h1c000200);
        for (int n = 0; n < 8; n++) step();

        // Randomized latency, stalls and redirects
        resp_mode = 1; since = 0; pop_cnt = 0;
        for (int n = 0; n < 2000; n++) begin
            id_allow_in = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 99) < 4 || since >= 60) begin
                wpc = 32'h1c000000 + ($urandom_range(0, 1023) << 2);
                bpc = 32'h1c000000 + ($urandom_range(0, 1023) << 2);
                if ($urandom_range(0, 9) == 0) wpc[1:0] = 2'($urandom_range(1, 3));
                if ($urandom_range(0, 9) == 0) bpc[1:0] = 2'($urandom_range(1, 3));
                sel = int'($urandom_range(0, 9));
                wb_flush = (sel < 4); br_taken = (sel >= 2);
                wb_flush_pc = wpc; br_target = bpc;
                sb_restart(wb_flush ? wpc : bpc);
                since = 0;
            end else begin
                wb_flush = 1'b0; br_taken = 1'b0;
                since++;
            end
            step();
        end
        wb_flush = 1'b0; br_taken = 1'b0; id_allow_in = 1'b1; resp_mode = 0;
        for (int n = 0; n < 20; n++) step();
        chk(pop_cnt > 100, "random_phase_pops", 32'(pop_cnt), 32'd101);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
